// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Sequences the instruction register through fetch, load and
//            execute; edge-detects push-buttons and owns the program counter.
//            Optional macro FETCH_SEQUENCER_AUTO_RUN_EN enables free-running
//            program execution.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int ADDR_W   = 4,
    parameter int PC_RESET = 0
) (
    input  logic              CLK,
    input  logic              clear,
    input  logic              step_btn,
    input  logic              ext_btn,
    input  logic              halt_in,
    input  logic              exec_done,
    output logic [ADDR_W-1:0] im_addr,
    output logic              ir_load,
    output logic              ir_src_ext,
    output logic              exec_start,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] c_pc_reset = ADDR_W'(PC_RESET);
    localparam logic [ADDR_W-1:0] c_pc_one   = {{(ADDR_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_fetch    = 3'd1;
    localparam logic [2:0] c_load_im  = 3'd2;
    localparam logic [2:0] c_load_ext = 3'd3;
    localparam logic [2:0] c_exec     = 3'd4;
    localparam logic [2:0] c_halt     = 3'd5;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_step_prev;
    logic       r_ext_prev;
    logic       w_step_req;
    logic       w_ext_req;

`ifdef FETCH_SEQUENCER_AUTO_RUN_EN
    logic r_run;
    logic r_pause;
    logic w_pause_now;
`endif

    assign w_step_req = step_btn & ~r_step_prev;
    assign w_ext_req  = ext_btn & ~r_ext_prev;

`ifdef FETCH_SEQUENCER_AUTO_RUN_EN
    // A request arriving on the very exec_done cycle also stops the run.
    assign w_pause_now = r_pause | w_step_req | w_ext_req;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_step_req && !w_ext_req)
                    w_state_nxt = c_fetch;
                else if (w_ext_req && !w_step_req)
                    w_state_nxt = c_load_ext;
            end
            c_fetch:    w_state_nxt = c_load_im;
            c_load_im:  w_state_nxt = c_exec;
            c_load_ext: w_state_nxt = c_exec;
            c_exec: begin
                if (exec_done) begin
                    if (halt_in)
                        w_state_nxt = c_halt;
`ifdef FETCH_SEQUENCER_AUTO_RUN_EN
                    else if (r_run && !w_pause_now)
                        w_state_nxt = c_fetch;
`endif
                    else
                        w_state_nxt = c_idle;
                end
            end
            c_halt:  w_state_nxt = c_halt;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            r_state     <= c_idle;
            r_step_prev <= 1'b1;
            r_ext_prev  <= 1'b1;
            pc          <= c_pc_reset;
            im_addr     <= c_pc_reset;
            ir_load     <= 1'b0;
            ir_src_ext  <= 1'b0;
            exec_start  <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_prev <= step_btn;
            r_ext_prev  <= ext_btn;
            ir_load     <= (w_state_nxt == c_load_im) || (w_state_nxt == c_load_ext);
            if ((w_state_nxt == c_load_im) || (w_state_nxt == c_load_ext))
                ir_src_ext <= (w_state_nxt == c_load_ext);
            exec_start  <= (w_state_nxt == c_exec) && (r_state != c_exec);
            busy        <= (w_state_nxt != c_idle) && (w_state_nxt != c_halt);
            halted      <= (w_state_nxt == c_halt);
            // The IM word has been captured into IR; advance to the next one.
            if (r_state == c_load_im) begin
                pc      <= pc + c_pc_one;
                im_addr <= pc + c_pc_one;
            end
        end
    end

`ifdef FETCH_SEQUENCER_AUTO_RUN_EN
    always_ff @(posedge CLK) begin
        if (clear) begin
            r_run   <= 1'b0;
            r_pause <= 1'b0;
        end else begin
            if (r_state == c_idle && w_state_nxt == c_fetch)
                r_run <= 1'b1;
            else if (w_state_nxt == c_idle || w_state_nxt == c_load_ext)
                r_run <= 1'b0;

            if (w_state_nxt == c_idle)
                r_pause <= 1'b0;
            else if (r_run && r_state != c_idle && (w_step_req || w_ext_req))
                r_pause <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
